// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with frame-level debounce,
// multi-key (ghosting) rejection and single-pulse key events.
module keypad_scanner #(
  parameter int unsigned SCAN_DELAY     = 2500,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_key
);

  localparam int unsigned DWELL_W = (SCAN_DELAY > 1) ? $clog2(SCAN_DELAY) : 1;
  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DELAY - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    CAND_NONE   = 2'd0,
    CAND_SINGLE = 2'd1,
    CAND_MULTI  = 2'd2
  } cand_kind_t;

  // idx is forced to zero for NONE/MULTI so whole-struct equality is meaningful
  typedef struct packed {
    cand_kind_t kind;
    logic [3:0] idx;
  } cand_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_MULTI   = 2'd2
  } state_t;

  logic [3:0]         row_meta;
  logic [3:0]         row_sync;
  logic [1:0]         col_idx;
  logic [DWELL_W-1:0] dwell;
  logic [15:0]        frame;
  logic               frame_done;
  cand_t              cand;
  cand_t              prev_cand;
  logic [CNT_W-1:0]   stable_cnt;
  logic [CNT_W-1:0]   next_cnt;
  logic               same;
  logic               qualify;
  state_t             state;

  // Synchronize rows, step the column/dwell counters and capture frame bits
  always_ff @(posedge clk) begin
    if (reset) begin
      row_meta   <= 4'b1111;
      row_sync   <= 4'b1111;
      col_idx    <= 2'd0;
      dwell      <= '0;
      col_out    <= 4'b1110;
      frame      <= '0;
      frame_done <= 1'b0;
    end else begin
      row_meta   <= row_in;
      row_sync   <= row_meta;
      col_out    <= ~(4'b0001 << col_idx);
      frame_done <= 1'b0;
      if (dwell == DWELL_LAST) begin
        frame[{col_idx, 2'b00} +: 4] <= ~row_sync;
        dwell                        <= '0;
        col_idx                      <= col_idx + 2'd1;
        frame_done                   <= (col_idx == 2'd3);
      end else begin
        dwell <= dwell + DWELL_W'(1);
      end
    end
  end

  // Classify the completed frame into NONE / SINGLE(i) / MULTI
  always_comb begin
    logic [4:0] ones;
    logic [3:0] pos;
    ones = '0;
    pos  = '0;
    for (int i = 0; i < 16; i++) begin
      if (frame[i]) begin
        ones = ones + 5'd1;
        pos  = 4'(i);
      end
    end
    cand.kind = CAND_NONE;
    cand.idx  = 4'd0;
    if (ones == 5'd1) begin
      cand.kind = CAND_SINGLE;
      cand.idx  = pos;
    end else if (ones != 5'd0) begin
      cand.kind = CAND_MULTI;
    end
  end

  // Next debounce count and the qualifying-frame strobe
  always_comb begin
    same     = (cand == prev_cand);
    next_cnt = CNT_W'(1);
    if (same) begin
      next_cnt = (stable_cnt == CNT_MAX) ? CNT_MAX : stable_cnt + CNT_W'(1);
    end
    qualify = frame_done && (next_cnt == CNT_MAX) &&
              !(same && (stable_cnt == CNT_MAX));
  end

  // Debounce history, updated once per completed frame
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_cand  <= '{kind: CAND_NONE, idx: 4'd0};
      stable_cnt <= '0;
    end else if (frame_done) begin
      prev_cand  <= cand;
      stable_cnt <= next_cnt;
    end
  end

  // Key-event FSM; only qualifying frames move it
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      multi_key <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (qualify) begin
        case (state)
          ST_IDLE: begin
            if (cand.kind == CAND_SINGLE) begin
              state     <= ST_PRESSED;
              key_code  <= cand.idx;
              key_valid <= 1'b1;
              key_held  <= 1'b1;
            end else if (cand.kind == CAND_MULTI) begin
              state     <= ST_MULTI;
              multi_key <= 1'b1;
            end
          end
          ST_PRESSED: begin
            if (cand.kind == CAND_NONE) begin
              state    <= ST_IDLE;
              key_held <= 1'b0;
            end else if (cand.kind == CAND_MULTI) begin
              state     <= ST_MULTI;
              key_held  <= 1'b0;
              multi_key <= 1'b1;
            end else if (cand.idx != key_code) begin
              key_code  <= cand.idx;
              key_valid <= 1'b1;
            end
          end
          ST_MULTI: begin
            if (cand.kind == CAND_NONE) begin
              state     <= ST_IDLE;
              multi_key <= 1'b0;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed table-driven bench with a behavioral keypad matrix.
module tb_keypad_scanner;

  localparam int unsigned SCAN_DELAY     = 4;
  localparam int unsigned DEBOUNCE_SCANS = 2;
  localparam int FRAME = 4 * SCAN_DELAY;

  logic       clk;
  logic       reset;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       multi_key;

  logic [15:0] keys;
  int checks;
  int failures;
  int pulses;

  typedef struct {
    logic [15:0] keys;
    int          frames;
    int          pulses;
    logic [3:0]  code;
    logic        held;
    logic        multi;
  } vec_t;

  vec_t vecs[$];

  keypad_scanner #(
    .SCAN_DELAY(SCAN_DELAY),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .row_in(row_in),
    .col_out(col_out),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held),
    .multi_key(multi_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: key index c*4+r pulls row r low while column c is driven low
  always_comb begin
    row_in = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (keys[c*4+r] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      if (key_valid) pulses++;
    end
  endtask

  task automatic add_vec(input logic [15:0] k, input int f, input int p,
                         input logic [3:0] code, input logic held, input logic multi);
    vec_t v;
    v.keys = k; v.frames = f; v.pulses = p; v.code = code; v.held = held; v.multi = multi;
    vecs.push_back(v);
  endtask

  initial begin
    logic [3:0] exp_col;
    checks   = 0;
    failures = 0;
    pulses   = 0;
    keys     = '0;
    reset    = 1'b1;

    // Bits: 9=(2,1), 3=(0,3), 0=(0,0), 15=(3,3)
    add_vec(16'h0200, 2, 1, 4'd9, 1'b1, 1'b0);
    add_vec(16'h0200, 3, 0, 4'd9, 1'b1, 1'b0);
    add_vec(16'h0000, 1, 0, 4'd9, 1'b1, 1'b0);
    add_vec(16'h0000, 1, 0, 4'd9, 1'b0, 1'b0);
    add_vec(16'h0200, 2, 1, 4'd9, 1'b1, 1'b0);
    add_vec(16'h0008, 2, 1, 4'd3, 1'b1, 1'b0);
    add_vec(16'h0000, 2, 0, 4'd3, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      add_vec((i % 2 == 0) ? 16'h0200 : 16'h0000, 1, 0, 4'd3, 1'b0, 1'b0);
    end
    add_vec(16'h8001, 2, 0, 4'd3, 1'b0, 1'b1);
    add_vec(16'h0001, 2, 0, 4'd3, 1'b0, 1'b1);
    add_vec(16'h0000, 1, 0, 4'd3, 1'b0, 1'b1);
    add_vec(16'h0000, 1, 0, 4'd3, 1'b0, 1'b0);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset col_out", int'(col_out), 4'b1110);
    check("reset key_code", int'(key_code), 0);
    check("reset key_valid", int'(key_valid), 0);
    check("reset key_held", int'(key_held), 0);
    check("reset multi_key", int'(multi_key), 0);
    reset = 1'b0;
    @(negedge clk);

    // Free-run column sequence, 4 cycles per column
    for (int k = 0; k <= FRAME; k++) begin
      if (k != 0) @(negedge clk);
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      check($sformatf("freerun col_out k=%0d", k), int'(col_out), int'(exp_col));
      if (key_valid || key_held || multi_key || key_code != 4'd0)
        check($sformatf("freerun idle outputs k=%0d", k), 1, 0);
    end

    // Table-driven frames
    for (int i = 0; i < vecs.size(); i++) begin
      keys   = vecs[i].keys;
      pulses = 0;
      run_cycles(vecs[i].frames * FRAME);
      check($sformatf("vec%0d pulses", i), pulses, vecs[i].pulses);
      check($sformatf("vec%0d key_code", i), int'(key_code), int'(vecs[i].code));
      check($sformatf("vec%0d key_held", i), int'(key_held), int'(vecs[i].held));
      check($sformatf("vec%0d multi_key", i), int'(multi_key), int'(vecs[i].multi));
    end

    // Reset mid-press with (1,2) held
    keys   = 16'h0040;
    pulses = 0;
    run_cycles(2 * FRAME);
    check("pre-reset pulses", pulses, 1);
    check("pre-reset key_code", int'(key_code), 6);
    check("pre-reset key_held", int'(key_held), 1);
    run_cycles(5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset col_out", int'(col_out), 4'b1110);
    check("midreset key_code", int'(key_code), 0);
    check("midreset key_held", int'(key_held), 0);
    check("midreset key_valid", int'(key_valid), 0);
    @(negedge clk);
    pulses = 0;
    run_cycles(FRAME);
    check("post-reset frame1 pulses", pulses, 0);
    check("post-reset frame1 key_held", int'(key_held), 0);
    run_cycles(FRAME);
    check("post-reset frame2 pulses", pulses, 1);
    check("post-reset frame2 key_code", int'(key_code), 6);
    check("post-reset frame2 key_held", int'(key_held), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
